// File: rtl/mult_pkg.sv
// Shared definitions for the sequential multiplier: controller state encoding and default width.
package mult_pkg;

    localparam int MULT_N = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/Full_Adder.sv
// One-bit full adder cell used to build the ripple chain of the add/shift row.
module Full_Adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/shift_add_row.sv
// Combinational add/shift row: conditionally adds M into A (when Q[0] is set),
// then shifts the (2N+1)-bit {sum, Q} right by one.
module shift_add_row #(
    parameter int N = 4
) (
    input  logic [N:0]   A,
    input  logic [N-1:0] Q,
    input  logic [N-1:0] M,
    output logic [N:0]   nextA,
    output logic [N-1:0] nextQ
);

    logic [N-1:0] addend;
    logic [N:0]   carry;
    logic [N:0]   sum;

    assign addend   = M & {N{Q[0]}};
    assign carry[0] = 1'b0;

    for (genvar i = 0; i < N; i++) begin : gRipple
        Full_Adder uFa (
            .a   (A[i]),
            .b   (addend[i]),
            .cin (carry[i]),
            .sum (sum[i]),
            .cout(carry[i+1])
        );
    end

    // Top bit only absorbs the ripple carry; the addend has no bit N.
    assign sum[N] = A[N] ^ carry[N];

    assign nextA = {1'b0, sum[N:1]};
    assign nextQ = {sum[0], Q[N-1:1]};

endmodule

// File: rtl/seq_multiplier_ctrl.sv
// Sequential shift-and-add multiplier: one add/shift row reused for N cycles,
// with a start/busy/done handshake and a registered 2N-bit product.
module seq_multiplier_ctrl
    import mult_pkg::*;
#(
    parameter int N = MULT_N
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           start,
    input  logic [N-1:0]   inputM,
    input  logic [N-1:0]   inputQ,
    output logic           busy,
    output logic           done,
    output logic [2*N-1:0] product
);

    localparam int CW = $clog2(N + 1);
    localparam logic [CW-1:0] LAST_STEP = CW'(N - 1);

    state_t        state;
    logic [N:0]    regA;
    logic [N-1:0]  regQ;
    logic [N-1:0]  regM;
    logic [CW-1:0] count;
    logic [N:0]    nextA;
    logic [N-1:0]  nextQ;

    shift_add_row #(.N(N)) uRow (
        .A    (regA),
        .Q    (regQ),
        .M    (regM),
        .nextA(nextA),
        .nextQ(nextQ)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= ST_IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
            product <= '0;
            regA    <= '0;
            regQ    <= '0;
            regM    <= '0;
            count   <= '0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        regM  <= inputM;
                        regQ  <= inputQ;
                        regA  <= '0;
                        count <= '0;
                        busy  <= 1'b1;
                        state <= ST_RUN;
                    end else begin
                        state <= ST_IDLE;
                    end
                end
                ST_RUN: begin
                    regA  <= nextA;
                    regQ  <= nextQ;
                    count <= count + 1'b1;
                    // Product is taken from the row outputs so the final step lands in the same edge.
                    if (count == LAST_STEP) begin
                        product <= {nextA[N-1:0], nextQ};
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        state   <= ST_DONE;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_multiplier_ctrl.sv
// Self-checking bench for seq_multiplier_ctrl (N=4): table-driven operations,
// hand-written corner sequences and random traffic against a cycle-level model.
module tb_seq_multiplier_ctrl;

    localparam int N = 4;

    logic           clk = 1'b0;
    logic           reset;
    logic           start;
    logic [N-1:0]   inputM;
    logic [N-1:0]   inputQ;
    logic           busy;
    logic           done;
    logic [2*N-1:0] product;

    int errors = 0;
    int checks = 0;

    // Model: phase 0 = idle, 1..N = busy cycles, N+1 = done cycle.
    int             mdlPhase = 0;
    logic [2*N-1:0] mdlProd = '0;
    logic [N-1:0]   mdlM = '0;
    logic [N-1:0]   mdlQ = '0;

    typedef struct {
        logic [N-1:0]   m;
        logic [N-1:0]   q;
        logic [2*N-1:0] expProd;
    } vec_t;

    vec_t vecs[8];

    seq_multiplier_ctrl #(.N(N)) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .inputM (inputM),
        .inputQ (inputQ),
        .busy   (busy),
        .done   (done),
        .product(product)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Advance the model by one edge using the currently driven inputs, clock the DUT, compare.
    task automatic stepCycle();
        if (reset) begin
            mdlPhase = 0;
            mdlProd  = '0;
        end else if ((mdlPhase == 0 || mdlPhase == N + 1) && start) begin
            mdlPhase = 1;
            mdlM     = inputM;
            mdlQ     = inputQ;
        end else if (mdlPhase >= 1 && mdlPhase < N) begin
            mdlPhase++;
        end else if (mdlPhase == N) begin
            mdlPhase = N + 1;
            mdlProd  = {{N{1'b0}}, mdlM} * {{N{1'b0}}, mdlQ};
        end else begin
            mdlPhase = 0;
        end
        @(posedge clk);
        #1;
        check("model_busy", 64'(busy), 64'(mdlPhase >= 1 && mdlPhase <= N));
        check("model_done", 64'(done), 64'(mdlPhase == N + 1));
        check("model_product", 64'(product), 64'(mdlProd));
    endtask

    // One isolated operation with explicit latency and value checks; operands scrambled after accept.
    task automatic doOp(input logic [N-1:0] m, input logic [N-1:0] q, input logic [2*N-1:0] expProd);
        start  = 1'b1;
        inputM = m;
        inputQ = q;
        stepCycle();
        start  = 1'b0;
        for (int unsigned c = 1; c <= N; c++) begin
            inputM = N'($urandom);
            inputQ = N'($urandom);
            check("op_busy", 64'(busy), 64'd1);
            check("op_done_early", 64'(done), 64'd0);
            stepCycle();
        end
        check("op_done", 64'(done), 64'd1);
        check("op_busy_done", 64'(busy), 64'd0);
        check("op_product", 64'(product), 64'(expProd));
        stepCycle();
        check("op_done_pulse", 64'(done), 64'd0);
        check("op_hold", 64'(product), 64'(expProd));
    endtask

    initial begin
        vecs[0] = '{m: 4'd13, q: 4'd11, expProd: 8'h8F};
        vecs[1] = '{m: 4'd15, q: 4'd15, expProd: 8'hE1};
        vecs[2] = '{m: 4'd0,  q: 4'd9,  expProd: 8'h00};
        vecs[3] = '{m: 4'd9,  q: 4'd0,  expProd: 8'h00};
        vecs[4] = '{m: 4'd1,  q: 4'd15, expProd: 8'h0F};
        vecs[5] = '{m: 4'd15, q: 4'd1,  expProd: 8'h0F};
        vecs[6] = '{m: 4'd10, q: 4'd6,  expProd: 8'h3C};
        vecs[7] = '{m: 4'd8,  q: 4'd8,  expProd: 8'h40};

        reset  = 1'b1;
        start  = 1'b0;
        inputM = '0;
        inputQ = '0;

        // Reset held 3 cycles, then idle 5 cycles.
        for (int unsigned i = 0; i < 3; i++) stepCycle();
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_product", 64'(product), 64'h00);
        reset = 1'b0;
        for (int unsigned i = 0; i < 5; i++) stepCycle();
        check("idle_busy", 64'(busy), 64'd0);
        check("idle_done", 64'(done), 64'd0);
        check("idle_product", 64'(product), 64'h00);

        foreach (vecs[i]) doOp(vecs[i].m, vecs[i].q, vecs[i].expProd);

        // Start during RUN is ignored.
        start = 1'b1; inputM = 4'd7; inputQ = 4'd6;
        stepCycle();                          // cycle 1
        start = 1'b0;
        stepCycle();                          // cycle 2
        start = 1'b1; inputM = 4'd15; inputQ = 4'd15;
        stepCycle();                          // cycle 3
        stepCycle();                          // cycle 4
        start = 1'b0;
        stepCycle();                          // cycle 5
        check("ignore_done", 64'(done), 64'd1);
        check("ignore_product", 64'(product), 64'h2A);
        for (int unsigned i = 0; i < 6; i++) begin
            stepCycle();
            check("ignore_no_second_done", 64'(done), 64'd0);
        end

        // Back-to-back: new start accepted in the done cycle.
        start = 1'b1; inputM = 4'd3; inputQ = 4'd5;
        stepCycle();                          // cycle 1
        start = 1'b0;
        for (int unsigned i = 0; i < 4; i++) stepCycle();
        check("b2b_first_done", 64'(done), 64'd1);
        check("b2b_first_product", 64'(product), 64'h0F);
        start = 1'b1; inputM = 4'd10; inputQ = 4'd12;
        stepCycle();                          // cycle 6
        start = 1'b0;
        check("b2b_busy_again", 64'(busy), 64'd1);
        check("b2b_old_product", 64'(product), 64'h0F);
        for (int unsigned i = 0; i < 4; i++) stepCycle();
        check("b2b_second_done", 64'(done), 64'd1);
        check("b2b_second_product", 64'(product), 64'h78);
        stepCycle();

        // Reset in the middle of an operation discards it.
        start = 1'b1; inputM = 4'd12; inputQ = 4'd12;
        stepCycle();                          // cycle 1
        start = 1'b0;
        stepCycle();                          // cycle 2
        stepCycle();                          // cycle 3
        reset = 1'b1;
        stepCycle();                          // cycle 4
        reset = 1'b0;
        check("midrst_busy", 64'(busy), 64'd0);
        check("midrst_done", 64'(done), 64'd0);
        check("midrst_product", 64'(product), 64'h00);
        for (int unsigned i = 0; i < 6; i++) begin
            stepCycle();
            check("midrst_no_done", 64'(done), 64'd0);
        end
        doOp(4'd2, 4'd3, 8'h06);

        // Reset and start together: reset wins.
        reset = 1'b1; start = 1'b1; inputM = 4'd5; inputQ = 4'd5;
        stepCycle();
        reset = 1'b0; start = 1'b0;
        check("rst_start_busy", 64'(busy), 64'd0);

        // Random traffic against the model.
        for (int unsigned i = 0; i < 400; i++) begin
            start  = ($urandom_range(0, 2) == 0);
            reset  = ($urandom_range(0, 39) == 0);
            inputM = N'($urandom);
            inputQ = N'($urandom);
            stepCycle();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
